// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, flag bit positions and flag bundle
// shared by the ALU pipeline and its compute core.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_ADDC = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ILL   = 4;

  typedef struct packed {
    logic illegal;
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational compute between S1 and S2.
// ALU_PIPE_MUL_EN adds opcode 11 (low half of unsigned a*b).
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             carry_q,
  output logic [WIDTH-1:0] res,
  output logic [4:0]       flags,
  output logic             carry_we,
  output logic             carry_nx
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;
  logic [WIDTH:0] adc_w;
  logic           ovf_add;
  logic           ovf_sub;
  logic           ovf_adc;
  logic           lt_s;
  logic           lt_u;
  logic           c;
  logic           v;
  logic           ill;
  alu_flags_t     fl;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign adc_w = add_w + {{WIDTH{1'b0}}, carry_q};

  assign ovf_add = (a[MSB] == b[MSB]) &&
                   (add_w[MSB] != a[MSB]);
  assign ovf_adc = (a[MSB] == b[MSB]) &&
                   (adc_w[MSB] != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) &&
                   (sub_w[MSB] != a[MSB]);

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  // Opcode decode; shifts by >= WIDTH fall out of the shift operators.
  always_comb begin
    res      = '0;
    c        = 1'b0;
    v        = 1'b0;
    ill      = 1'b0;
    carry_we = 1'b0;
    case (op)
      OP_ADD: begin
        res      = add_w[MSB:0];
        c        = add_w[WIDTH];
        v        = ovf_add;
        carry_we = 1'b1;
      end
      OP_SUB: begin
        res      = sub_w[MSB:0];
        c        = sub_w[WIDTH];
        v        = ovf_sub;
        carry_we = 1'b1;
      end
      OP_ADDC: begin
        res      = adc_w[MSB:0];
        c        = adc_w[WIDTH];
        v        = ovf_adc;
        carry_we = 1'b1;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b;
      OP_SHR:  res = a >> b;
      OP_SRA:  res = $signed(a) >>> b;
      OP_SLT:  res = {{MSB{1'b0}}, lt_s};
      OP_SLTU: res = {{MSB{1'b0}}, lt_u};
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  res = a * b;
`endif
      default: ill = 1'b1;
    endcase
  end

  assign carry_nx    = c;
  assign fl.illegal  = ill;
  assign fl.carry    = c;
  assign fl.overflow = v;
  assign fl.negative = res[MSB];
  assign fl.zero     = !ill && (res == '0);
  assign flags       = fl;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with ADDC carry chain.
// ALU_PIPE_MUL_EN enables the multiply opcode in the core.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       opcode,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;
  logic             carry_q;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] core_res;
  logic [4:0]       core_flags;
  logic             carry_we;
  logic             carry_nx;

  assign s2_load = !valid_o || ready_i;
  assign s1_load = !s1_valid || s2_load;
  assign ready_o = s1_load;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a        (s1_a),
    .b        (s1_b),
    .op       (s1_op),
    .carry_q  (carry_q),
    .res      (core_res),
    .flags    (core_flags),
    .carry_we (carry_we),
    .carry_nx (carry_nx)
  );

  // S1: capture request when the slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_a  <= operand_a;
        s1_b  <= operand_b;
        s1_op <= opcode;
      end
    end
  end

  // S2: register result/flags, update ADDC carry on the same move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      result  <= '0;
      flags   <= '0;
      carry_q <= 1'b0;
    end else if (s2_load) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        result <= core_res;
        flags  <= core_flags;
        if (carry_we) carry_q <= carry_nx;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors, queue scoreboard, monitor
// checking order, stall stability and ready_o behaviour.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [3:0] opcode;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] result;
  logic [4:0] flags;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  logic [12:0] q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ready_i: 0 = always 1, 1 = toggle 1010, 2 = held low
  initial begin
    ready_i = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       ready_i = ~ready_i;
        2:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
    end
  end

  // monitor: pop on output transfer, check stalls and ready_o
  initial begin
    logic        held;
    logic [12:0] hv;
    logic [12:0] e;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        check("ready_o", ready_o,
              !(q.size() == 2 && !ready_i));
        if (held)
          check("stall_hold", {result, flags}, hv);
        held = valid_o && !ready_i;
        hv   = {result, flags};
        if (valid_o && ready_i) begin
          if (q.size() == 0) begin
            check("unexpected_out", {result, flags}, 13'h1fff);
            if ({result, flags} == 13'h1fff) n_bad++;
          end else begin
            e = q.pop_front();
            check("result_flags", {result, flags}, e);
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] er,
                      input logic [4:0] ef);
    bit fire;
    int n;
    n = 0;
    fire = 0;
    @(negedge clk);
    valid_i   = 1'b1;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    while (!fire) begin
      #1 fire = ready_o;
      @(posedge clk);
      if (fire) begin
        q.push_back({er, ef});
      end else begin
        n++;
        if (n > 50) begin
          n_vec++;
          n_bad++;
          $display("FAIL accept_timeout: op %0d not accepted", op);
          fire = 1;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d left, expected 0", q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    operand_a = '0;
    operand_b = '0;
    opcode    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_ready_o", ready_o, 1'b1);
    check("rst_result", result, 8'h00);
    check("rst_flags", flags, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // flags = {illegal, carry, overflow, negative, zero}
    send(4'd0,  8'hF0, 8'h20, 8'h10, 5'b01000);
    send(4'd8,  8'h01, 8'h00, 8'h02, 5'b00000);
    send(4'd1,  8'h80, 8'h01, 8'h7F, 5'b00100);
    send(4'd1,  8'h03, 8'h05, 8'hFE, 5'b01010);
    send(4'd7,  8'h90, 8'h02, 8'hE4, 5'b00010);
    send(4'd5,  8'h01, 8'h09, 8'h00, 5'b00001);
    send(4'd9,  8'hFF, 8'h01, 8'h01, 5'b00000);
    send(4'd10, 8'hFF, 8'h01, 8'h00, 5'b00001);
    send(4'd15, 8'h12, 8'h34, 8'h00, 5'b10000);
`ifdef ALU_PIPE_MUL_EN
    send(4'd11, 8'h03, 8'h04, 8'h0C, 5'b00000);
`else
    send(4'd11, 8'h03, 8'h04, 8'h00, 5'b10000);
`endif
    send(4'd8,  8'h01, 8'h01, 8'h03, 5'b00000);
    idle();
    drain();

    rdy_mode = 1;
    send(4'd2, 8'hF0, 8'h3C, 8'h30, 5'b00000);
    send(4'd3, 8'hF0, 8'h0F, 8'hFF, 5'b00010);
    send(4'd4, 8'hAA, 8'hAA, 8'h00, 5'b00001);
    send(4'd6, 8'h80, 8'h07, 8'h01, 5'b00000);
    send(4'd6, 8'h80, 8'h08, 8'h00, 5'b00001);
    send(4'd7, 8'h80, 8'h08, 8'hFF, 5'b00010);
    send(4'd0, 8'h7F, 8'h01, 8'h80, 5'b00110);
    send(4'd0, 8'hFF, 8'h01, 8'h00, 5'b01001);
    idle();
    drain();

    rdy_mode = 2;
    send(4'd0, 8'hFF, 8'hFF, 8'hFE, 5'b01010);
    send(4'd0, 8'h01, 8'h01, 8'h02, 5'b00000);
    idle();
    @(negedge clk);
    #1;
    check("stall_full_ready", ready_o, 1'b0);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid_o", valid_o, 1'b0);
    check("mid_rst_ready_o", ready_o, 1'b1);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_flags", flags, 5'b00000);
    rdy_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_no_out", valid_o, 1'b0);
    end
    send(4'd8, 8'h01, 8'h01, 8'h02, 5'b00000);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
